// File: rtl/cdb_rr_scheduler.sv
// Round-robin arbiter sharing one common data bus among N result ports.
// The granted tag/value/source is registered and broadcast one cycle later.
module cdb_rr_scheduler #(
  parameter int N         = 16,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5,
  localparam int IW       = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*TAG_WIDTH-1:0] req_tag,
  input  logic [N*XLEN-1:0]      req_value,
  output logic [N-1:0]           req_ready,
  input  logic                   flush,
  output logic                   cdb_valid,
  output logic [TAG_WIDTH-1:0]   cdb_tag,
  output logic [XLEN-1:0]        cdb_value,
  output logic [IW-1:0]          cdb_source
);

  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        win;
  logic [IW:0]          idx;
  logic                 found;
  logic                 grant;
  logic                 valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [XLEN-1:0]      value_q, value_d;
  logic [IW-1:0]        src_q, src_d;

  // Scan N slots starting at the pointer, wrapping past N-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) begin
        idx = idx - (IW+1)'(N);
      end
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign grant = found & ~flush & reset_n;

  always_comb begin
    req_ready = '0;
    ptr_d     = ptr_q;
    valid_d   = grant;
    tag_d     = tag_q;
    value_d   = value_q;
    src_d     = src_q;
    if (grant) begin
      req_ready = N'(1) << win;
      ptr_d     = (win == IW'(N-1)) ? '0 : win + 1'b1;
      tag_d     = req_tag[win*TAG_WIDTH +: TAG_WIDTH];
      value_d   = req_value[win*XLEN +: XLEN];
      src_d     = win;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
      src_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      value_q <= value_d;
      src_q   <= src_d;
    end
  end

  assign cdb_valid  = valid_q;
  assign cdb_tag    = tag_q;
  assign cdb_value  = value_q;
  assign cdb_source = src_q;

endmodule
